// File: rtl/parity_frame_sched_if.sv
// Request/result bundle between two frame requesters, the parity scheduler and its consumer.
// Latency: none, wires only.
// Backpressure: valid/ready on both request channels and on the result channel.
interface parity_frame_sched_if #(
    parameter int FRAME_CHARS = 16
);
    logic                     req0_valid;
    logic [FRAME_CHARS*8-1:0] req0_data;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [FRAME_CHARS*8-1:0] req1_data;
    logic                     req1_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [FRAME_CHARS*8-1:0] out_data;
    logic                     out_src;
    logic                     out_err;

    // Host / stimulus side: drives frames, consumes results.
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_src, out_err
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_src, out_err
    );
endinterface

// File: rtl/parity_frame_sched.sv
// Round-robin shares one serial odd-parity engine between two frame requesters, rewriting group separators.
// Latency: accept at cycle t -> out_valid at t+FRAME_CHARS+1; one frame per FRAME_CHARS+2 cycles best case.
// Backpressure: requesters see ready only in IDLE; result held stable in DONE until out_ready.
module parity_frame_sched #(
    parameter int         FRAME_CHARS = 16,
    parameter logic [7:0] SPACE_CHAR  = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset,
    parity_frame_sched_if.slave  bus
);
    localparam int W     = FRAME_CHARS * 8;
    localparam int IDX_W = (FRAME_CHARS > 1) ? $clog2(FRAME_CHARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     frame;
    logic [IDX_W-1:0] idx;
    logic             acc;
    logic             err;
    logic             src;
    logic             last_grant;

    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_src_q;
    logic             out_err_q;

    logic             grant0;
    logic             grant1;
    logic             take;

    logic [7:0]       cur_char;
    logic [7:0]       new_char;
    logic             acc_next;
    logic             err_next;
    logic [W-1:0]     frame_next;

    // Round-robin grant: a lone requester always wins, a tie goes to whoever was not served last.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && !grant0;
        take   = (state == IDLE) && (grant0 || grant1);
    end

    assign bus.req0_ready = (state == IDLE) && grant0;
    assign bus.req1_ready = (state == IDLE) && grant1;

    // Per-char parity step on the char under the scan index; non-binary chars count as '0' and flag the frame.
    always_comb begin
        cur_char = frame[int'(idx)*8 +: 8];
        new_char = cur_char;
        acc_next = acc;
        err_next = err;
        if (cur_char == 8'h31) begin
            acc_next = ~acc;
        end else if (cur_char == 8'h30) begin
            acc_next = acc;
        end else if (cur_char == SPACE_CHAR) begin
            new_char = acc ? 8'h30 : 8'h31;
            acc_next = 1'b0;
        end else begin
            err_next = 1'b1;
        end
        frame_next = frame;
        frame_next[int'(idx)*8 +: 8] = new_char;
    end

    // Scheduler FSM: accept a granted frame, scan it MSB char first, then present the result until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            frame       <= '0;
            idx         <= LAST_IDX;
            acc         <= 1'b0;
            err         <= 1'b0;
            src         <= 1'b0;
            last_grant  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        frame      <= grant0 ? bus.req0_data : bus.req1_data;
                        src        <= grant1;
                        last_grant <= grant1;
                        acc        <= 1'b0;
                        err        <= 1'b0;
                        idx        <= LAST_IDX;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    frame <= frame_next;
                    acc   <= acc_next;
                    err   <= err_next;
                    if (idx == '0) begin
                        // Trailing chars after the last separator get no parity char.
                        acc         <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= frame_next;
                        out_src_q   <= src;
                        out_err_q   <= err_next;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_parity_frame_sched.sv
// Bench for parity_frame_sched: queue-driven requesters, frame-level reference model, per-cycle compare.
// Latency: checks accept-to-valid distance and result-hold under backpressure.
// Backpressure: out_ready is driven low in places to hold results in DONE.
module tb_parity_frame_sched;
    typedef logic [127:0] frame_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    parity_frame_sched_if #(.FRAME_CHARS(16)) bus ();

    parity_frame_sched #(.FRAME_CHARS(16), .SPACE_CHAR(8'h20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Pending frames per requester, expected results, and delivered results.
    frame_t q0[$];
    frame_t q1[$];
    frame_t exp_d[$];
    logic   exp_s[$];
    logic   exp_e[$];
    frame_t log_d[$];
    logic   log_s[$];
    logic   log_e[$];
    int     log_lat[$];

    logic   busy = 1'b0;
    logic   lg   = 1'b1;
    int     acc_cyc = 0;
    logic   m_e0, m_e1, m_eov, m_err;
    frame_t m_frame;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk_vec(input string name, input frame_t act, input frame_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: each separator becomes the odd-parity char of the group of chars since the previous separator.
    function automatic frame_t model_frame(input frame_t f, output logic e);
        frame_t     o;
        int         start;
        int         ones;
        logic [7:0] c;
        o = f;
        e = 1'b0;
        start = 0;
        for (int p = 0; p < 16; p++) begin
            c = f[127-8*p -: 8];
            if (c == 8'h20) begin
                ones = 0;
                for (int q = start; q < p; q++)
                    if (f[127-8*q -: 8] == 8'h31) ones++;
                o[127-8*p -: 8] = (ones % 2 == 1) ? 8'h30 : 8'h31;
                start = p + 1;
            end else if (c != 8'h30 && c != 8'h31) begin
                e = 1'b1;
            end
        end
        return o;
    endfunction

    // Requester driver: present queue heads, retire a frame once it is accepted.
    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.req0_valid && bus.req0_ready) void'(q0.pop_front());
            if (!reset && bus.req1_valid && bus.req1_ready) void'(q1.pop_front());
            @(posedge clk);
            #1;
            bus.req0_valid = (q0.size() != 0);
            bus.req0_data  = (q0.size() != 0) ? q0[0] : '0;
            bus.req1_valid = (q1.size() != 0);
            bus.req1_data  = (q1.size() != 0) ? q1[0] : '0;
        end
    end

    // Compare process: arbitration, valid timing and result contents every cycle.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_d.delete();
            exp_s.delete();
            exp_e.delete();
            busy = 1'b0;
            lg   = 1'b1;
        end else begin
            m_e0  = !busy && bus.req0_valid && (!bus.req1_valid || lg);
            m_e1  = !busy && bus.req1_valid && !(bus.req0_valid && lg);
            m_eov = busy && (cyc - acc_cyc >= 17);
            chk_bit("req0_ready", bus.req0_ready, m_e0);
            chk_bit("req1_ready", bus.req1_ready, m_e1);
            chk_bit("out_valid", bus.out_valid, m_eov);
            if (bus.out_valid && m_eov) begin
                if (exp_d.size() == 0) begin
                    chk_int("result_pending", 0, 1);
                end else begin
                    chk_vec("out_data", bus.out_data, exp_d[0]);
                    chk_bit("out_src", bus.out_src, exp_s[0]);
                    chk_bit("out_err", bus.out_err, exp_e[0]);
                    if (bus.out_ready) begin
                        log_d.push_back(bus.out_data);
                        log_s.push_back(bus.out_src);
                        log_e.push_back(bus.out_err);
                        log_lat.push_back(cyc - acc_cyc);
                        void'(exp_d.pop_front());
                        void'(exp_s.pop_front());
                        void'(exp_e.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            if (m_e0 || m_e1) begin
                m_frame = model_frame(m_e0 ? bus.req0_data : bus.req1_data, m_err);
                exp_d.push_back(m_frame);
                exp_s.push_back(m_e1);
                exp_e.push_back(m_err);
                lg      = m_e1;
                busy    = 1'b1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && n < maxc) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk_bit("drain_timeout", (n >= maxc), 1'b0);
    endtask

    task automatic wait_busy(input int maxc);
        int n = 0;
        while (!busy && n < maxc) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk_bit("accept_timeout", (n >= maxc), 1'b0);
    endtask

    task automatic wait_out_valid(input int maxc);
        int n = 0;
        while (!bus.out_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk_bit("out_valid_timeout", (n >= maxc), 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        frame_t hold;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_bit("rst_out_valid", bus.out_valid, 1'b0);
        chk_vec("rst_out_data", bus.out_data, '0);
        chk_bit("rst_out_src", bus.out_src, 1'b0);
        chk_bit("rst_out_err", bus.out_err, 1'b0);
        #1;
        reset = 1'b0;

        // Single frame, latency and rewrite.
        base = log_d.size();
        q0.push_back("000 001 011 111 ");
        wait_idle(100);
        chk_int("t1_count", log_d.size(), base + 1);
        if (log_d.size() >= base + 1) begin
            chk_vec("t1_data", log_d[base], "0001001001111110");
            chk_bit("t1_src", log_s[base], 1'b0);
            chk_bit("t1_err", log_e[base], 1'b0);
            chk_int("t1_latency", log_lat[base], 17);
        end

        // Both requesters after reset: strict alternation across four frames.
        pulse_reset();
        base = log_d.size();
        q0.push_back("000 001 011 111 ");
        q0.push_back("0000000000000000");
        q1.push_back("111 101 011 001 ");
        q1.push_back("0a1 001 011 111 ");
        wait_idle(200);
        chk_int("t2_count", log_d.size(), base + 4);
        if (log_d.size() >= base + 4) begin
            chk_bit("t2_src0", log_s[base],   1'b0);
            chk_bit("t2_src1", log_s[base+1], 1'b1);
            chk_bit("t2_src2", log_s[base+2], 1'b0);
            chk_bit("t2_src3", log_s[base+3], 1'b1);
            chk_vec("t2_data0", log_d[base],   "0001001001111110");
            chk_vec("t2_data1", log_d[base+1], "1110101101110010");
            chk_vec("t2_data2", log_d[base+2], "0000000000000000");
            chk_vec("t2_data3", log_d[base+3], "0a10001001111110");
            chk_bit("t2_err2", log_e[base+2], 1'b0);
            chk_bit("t2_err3", log_e[base+3], 1'b1);
        end

        // Result held in DONE while the consumer stalls; competing request must wait.
        base = log_d.size();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        q0.push_back("1 1 1 1 1 1 1 1 ");
        wait_out_valid(40);
        q1.push_back("111 101 011 001 ");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_bit("t4_hold_valid", bus.out_valid, 1'b1);
            chk_vec("t4_hold_data", bus.out_data, "1010101010101010");
            chk_bit("t4_hold_rdy1", bus.req1_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle(100);
        chk_int("t4_count", log_d.size(), base + 2);
        if (log_d.size() >= base + 2) begin
            chk_bit("t4_src0", log_s[base], 1'b0);
            chk_bit("t4_src1", log_s[base+1], 1'b1);
            chk_vec("t4_data1", log_d[base+1], "1110101101110010");
        end

        // Reset while scanning at char index 7.
        q0.push_back("111 101 011 001 ");
        wait_busy(40);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_bit("t6_scan_valid", bus.out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset while a flagged requester-1 result is held in DONE.
        bus.out_ready = 1'b0;
        q1.push_back("0a1 001 011 111 ");
        wait_out_valid(40);
        hold = bus.out_data;
        chk_vec("t6_done_data", hold, "0a10001001111110");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_bit("t6_rst_valid", bus.out_valid, 1'b0);
        chk_vec("t6_rst_data", bus.out_data, '0);
        chk_bit("t6_rst_src", bus.out_src, 1'b0);
        chk_bit("t6_rst_err", bus.out_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;

        // After reset, a tie goes to requester 0 and results are clean.
        base = log_d.size();
        q0.push_back("000 001 011 111 ");
        q1.push_back("111 101 011 001 ");
        wait_idle(200);
        chk_int("t6_count", log_d.size(), base + 2);
        if (log_d.size() >= base + 2) begin
            chk_bit("t6_src0", log_s[base], 1'b0);
            chk_vec("t6_data0", log_d[base], "0001001001111110");
            chk_bit("t6_err0", log_e[base], 1'b0);
            chk_bit("t6_src1", log_s[base+1], 1'b1);
            chk_vec("t6_data1", log_d[base+1], "1110101101110010");
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
